// File: rtl/fpga_ip_demo_sysid_checker.sv
// rtl/fpga_ip_demo_sysid_checker.sv - Avalon-MM master that reads system ID and build timestamp and checks them
// Reads word 0 then word 1 of the sysid slave and holds compare results until the next launch.
module fpga_ip_demo_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h6089_427A,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_FIN} state_t;

  localparam bit          ZERO_LAT = (READ_LATENCY == 0);
  localparam logic [2:0]  LAT_LOAD = ZERO_LAT ? 3'd0 : 3'(READ_LATENCY - 1);
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [2:0]  r_lat;
  logic [15:0] r_stall;
  logic        r_auto;
  logic        r_addr, r_read, r_busy, r_done, r_pass, r_id_ok, r_ts_ok, r_timeout;
  logic [31:0] r_id_value, r_ts_value;

  logic w_accept, w_stall_hit;

  assign w_accept    = r_read & ~avm_waitrequest;
  assign w_stall_hit = TO_EN && (r_stall == TO_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_lat      <= 3'd0;
      r_stall    <= 16'd0;
      r_auto     <= AUTO_START;
      r_addr     <= 1'b0;
      r_read     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_read <= 1'b0;
          if (start || r_auto) begin
            r_auto     <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
            r_read     <= 1'b1;
            r_addr     <= 1'b0;
            r_stall    <= 16'd0;
            r_state    <= S_RD_ID;
          end
        end
        S_RD_ID: begin
          // An accept in the same cycle the limit is reached still wins, so no read is left dangling.
          if (w_accept) begin
            r_stall <= 16'd0;
            if (ZERO_LAT) begin
              r_id_value <= avm_readdata;
              r_addr     <= 1'b1;
              r_state    <= S_RD_TS;
            end else begin
              r_read  <= 1'b0;
              r_lat   <= LAT_LOAD;
              r_state <= S_LAT_ID;
            end
          end else if (w_stall_hit) begin
            r_read    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_LAT_ID: begin
          if (r_lat == 3'd0) begin
            r_id_value <= avm_readdata;
            r_read     <= 1'b1;
            r_addr     <= 1'b1;
            r_stall    <= 16'd0;
            r_state    <= S_RD_TS;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_RD_TS: begin
          if (w_accept) begin
            r_stall <= 16'd0;
            r_read  <= 1'b0;
            if (ZERO_LAT) begin
              // Results are presented on FIN entry so done appears in the FIN cycle.
              r_ts_value <= avm_readdata;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_id_ok    <= (r_id_value == EXPECTED_ID);
              r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
              r_pass     <= (r_id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
              r_state    <= S_FIN;
            end else begin
              r_lat   <= LAT_LOAD;
              r_state <= S_LAT_TS;
            end
          end else if (w_stall_hit) begin
            r_read    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_stall <= r_stall + 16'd1;
          end
        end
        S_LAT_TS: begin
          if (r_lat == 3'd0) begin
            r_ts_value <= avm_readdata;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_id_ok    <= (r_id_value == EXPECTED_ID);
            r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            r_pass     <= (r_id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
            r_state    <= S_FIN;
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_FIN: begin
          // Re-evaluated here so the timeout path reports using whatever was captured.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_addr  <= 1'b0;
          r_id_ok <= (r_id_value == EXPECTED_ID);
          r_ts_ok <= (r_ts_value == EXPECTED_TIMESTAMP);
          r_pass  <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TIMESTAMP) && !r_timeout;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_address = r_addr;
  assign avm_read    = r_read;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign id_ok       = r_id_ok;
  assign ts_ok       = r_ts_ok;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_fpga_ip_demo_sysid_checker.sv
// tb/tb_fpga_ip_demo_sysid_checker.sv - bench for fpga_ip_demo_sysid_checker
// Two instances: A (latency 0, timeout 4) and B (latency 2, custom ID), each with its own slave model.
module tb_fpga_ip_demo_sysid_checker;

  localparam logic [31:0] EXP_ID_A = 32'h0000_0000;
  localparam logic [31:0] EXP_ID_B = 32'hCAFE_0001;
  localparam logic [31:0] EXP_TS   = 32'h6089_427A;
  localparam int          LAT_A    = 0;
  localparam int          LAT_B    = 2;
  localparam int          TO_A     = 4;

  logic clock;
  logic reset_n;
  logic start_a, start_b;

  logic        addr_a, read_a, wait_a, busy_a, done_a, pass_a, idok_a, tsok_a, to_a;
  logic [31:0] rdata_a, idv_a, tsv_a;
  logic        addr_b, read_b, wait_b, busy_b, done_b, pass_b, idok_b, tsok_b, to_b;
  logic [31:0] rdata_b, idv_b, tsv_b;

  int total = 0;
  int bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  fpga_ip_demo_sysid_checker #(
    .EXPECTED_ID(EXP_ID_A), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(LAT_A), .TIMEOUT_CYCLES(TO_A), .AUTO_START(1'b1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start_a),
    .avm_address(addr_a), .avm_read(read_a), .avm_readdata(rdata_a), .avm_waitrequest(wait_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .id_ok(idok_a), .ts_ok(tsok_a),
    .timeout(to_a), .id_value(idv_a), .ts_value(tsv_a)
  );

  fpga_ip_demo_sysid_checker #(
    .EXPECTED_ID(EXP_ID_B), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(LAT_B), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b), .avm_readdata(rdata_b), .avm_waitrequest(wait_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .id_ok(idok_b), .ts_ok(tsok_b),
    .timeout(to_b), .id_value(idv_b), .ts_value(tsv_b)
  );

  // Slave A: zero latency, stalls the first st_a[addr] cycles of each read.
  logic [31:0] mem_a [2];
  int st_a [2];
  int sc_a = 0;
  int nacc_a = 0;
  int n1_a = 0;
  assign wait_a  = read_a && (sc_a < st_a[addr_a]);
  assign rdata_a = (read_a && !wait_a) ? mem_a[addr_a] : 32'hBAD0_BAD0;
  always @(posedge clock) begin
    sc_a <= (read_a && wait_a) ? sc_a + 1 : 0;
    if (read_a && !wait_a) nacc_a <= nacc_a + 1;
    if (read_a && addr_a) n1_a <= n1_a + 1;
  end

  // Slave B: data valid exactly two cycles after accept, garbage otherwise.
  logic [31:0] mem_b [2];
  int st_b [2];
  int sc_b = 0;
  int nacc_b = 0;
  int viol_b = 0;
  logic [1:0] pv_b = 2'b00;
  logic [1:0] pa_b = 2'b00;
  logic prev_stall_b = 1'b0;
  logic prev_addr_b = 1'b0;
  assign wait_b  = read_b && (sc_b < st_b[addr_b]);
  assign rdata_b = pv_b[1] ? mem_b[pa_b[1]] : 32'hDEAD_BEEF;
  always @(posedge clock) begin
    sc_b <= (read_b && wait_b) ? sc_b + 1 : 0;
    if (read_b && !wait_b) nacc_b <= nacc_b + 1;
    pv_b <= {pv_b[0], read_b && !wait_b};
    pa_b <= {pa_b[0], addr_b};
    prev_stall_b <= read_b && wait_b && reset_n;
    prev_addr_b  <= addr_b;
    if (prev_stall_b && reset_n && (!read_b || addr_b != prev_addr_b)) viol_b <= viol_b + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits from cycle c0 onward for done on the selected instances; -1 means never seen.
  task automatic measure(input bit wa, input bit wb, input int c0, output int ca, output int cb);
    ca = -1;
    cb = -1;
    for (int c = c0; c < c0 + 300; c++) begin
      @(negedge clock);
      start_a = 1'b0;
      start_b = 1'b0;
      if (wa && ca < 0 && done_a) ca = c;
      if (wb && cb < 0 && done_b) cb = c;
      if ((!wa || ca >= 0) && (!wb || cb >= 0)) break;
    end
  endtask

  task automatic check_result(input int sel, input logic [31:0] w0, input logic [31:0] w1,
                              input bit to_exp, input int cyc_obs, input int cyc_exp, input string tag);
    logic [31:0] e_id;
    bit e_idok, e_tsok, e_pass;
    e_id   = (sel != 0) ? EXP_ID_B : EXP_ID_A;
    e_idok = (w0 == e_id);
    e_tsok = (w1 == EXP_TS);
    e_pass = e_idok && e_tsok && !to_exp;
    chk({tag, ":cycles"}, cyc_obs, cyc_exp);
    chk({tag, ":done"},  (sel != 0) ? done_b : done_a, 1);
    chk({tag, ":busy"},  (sel != 0) ? busy_b : busy_a, 0);
    chk({tag, ":pass"},  (sel != 0) ? pass_b : pass_a, e_pass);
    chk({tag, ":id_ok"}, (sel != 0) ? idok_b : idok_a, e_idok);
    chk({tag, ":ts_ok"}, (sel != 0) ? tsok_b : tsok_a, e_tsok);
    chk({tag, ":timeout"}, (sel != 0) ? to_b : to_a, to_exp);
    chk({tag, ":id_value"}, (sel != 0) ? idv_b : idv_a, w0);
    chk({tag, ":ts_value"}, (sel != 0) ? tsv_b : tsv_a, w1);
  endtask

  task automatic run_one(input int sel, input logic [31:0] w0, input logic [31:0] w1,
                         input int s0, input int s1, input string tag);
    int n0, ca, cb, lat;
    lat = (sel != 0) ? LAT_B : LAT_A;
    if (sel != 0) begin
      mem_b[0] = w0; mem_b[1] = w1; st_b[0] = s0; st_b[1] = s1;
    end else begin
      mem_a[0] = w0; mem_a[1] = w1; st_a[0] = s0; st_a[1] = s1;
    end
    @(negedge clock);
    n0 = (sel != 0) ? nacc_b : nacc_a;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock);
    measure(sel == 0, sel != 0, 1, ca, cb);
    check_result(sel, w0, w1, 1'b0, (sel != 0) ? cb : ca, 3 + 2 * lat + s0 + s1, tag);
    chk({tag, ":reads"}, ((sel != 0) ? nacc_b : nacc_a) - n0, 2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ":a_ctl"}, {24'd0, read_a, addr_a, busy_a, done_a, pass_a, idok_a, tsok_a, to_a}, 0);
    chk({tag, ":a_val"}, idv_a | tsv_a, 0);
    chk({tag, ":b_ctl"}, {24'd0, read_b, addr_b, busy_b, done_b, pass_b, idok_b, tsok_b, to_b}, 0);
    chk({tag, ":b_val"}, idv_b | tsv_b, 0);
  endtask

  initial begin
    int ca, cb, n0, n1;
    logic [31:0] w0, w1;
    start_a = 1'b0;
    start_b = 1'b0;
    reset_n = 1'b0;
    mem_a[0] = EXP_ID_A; mem_a[1] = EXP_TS; st_a[0] = 0; st_a[1] = 0;
    mem_b[0] = EXP_ID_B; mem_b[1] = EXP_TS; st_b[0] = 0; st_b[1] = 0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");

    // Auto-start after reset release on both instances.
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    measure(1'b1, 1'b1, 1, ca, cb);
    if (cb < 0) measure(1'b0, 1'b1, 1, n0, cb);
    check_result(0, EXP_ID_A, EXP_TS, 1'b0, ca, 3, "auto_a");
    @(negedge clock);
    check_result(1, EXP_ID_B, EXP_TS, 1'b0, cb, 7, "auto_b");

    run_one(0, 32'h0000_0001, EXP_TS, 0, 0, "bad_id");
    run_one(1, EXP_ID_B, EXP_TS, 0, 3, "lat2_stall");

    // Timeout: word 0 never accepted.
    st_a[0] = 1000;
    mem_a[0] = 32'h1234_5678;
    @(negedge clock);
    n0 = nacc_a;
    n1 = n1_a;
    start_a = 1'b1;
    @(posedge clock);
    measure(1'b1, 1'b0, 1, ca, cb);
    check_result(0, 32'd0, 32'd0, 1'b1, ca, 1 + TO_A + 2, "timeout");
    chk("timeout:read_dropped", read_a, 0);
    chk("timeout:accepts", nacc_a - n0, 0);
    chk("timeout:addr1_reads", n1_a - n1, 0);
    st_a[0] = 0;

    // Start re-pulsed while busy and in FIN: ignored.
    mem_a[0] = EXP_ID_A;
    mem_a[1] = EXP_TS;
    @(negedge clock);
    n0 = nacc_a;
    start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("launch:cycle1", {28'd0, read_a, addr_a, busy_a, done_a}, 4'b1010);
    @(negedge clock);
    start_a = 1'b0;
    @(negedge clock);
    chk("repulse:done_c3", done_a, 1);
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    repeat (5) @(negedge clock);
    chk("repulse:reads", nacc_a - n0, 2);
    chk("repulse:idle", {30'd0, busy_a, done_a}, 2'b01);

    // Start after done: done clears on cycle 1 and the check reruns.
    mem_a[1] = 32'h0000_4242;
    @(negedge clock);
    start_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_a = 1'b0;
    chk("rerun:cycle1", {30'd0, busy_a, done_a}, 2'b10);
    measure(1'b1, 1'b0, 2, ca, cb);
    check_result(0, EXP_ID_A, 32'h0000_4242, 1'b0, ca, 3, "rerun");
    mem_a[1] = EXP_TS;

    // Reset during LAT_TS on B (cycles 5-6), then fresh auto check.
    mem_b[0] = EXP_ID_B;
    mem_b[1] = EXP_TS;
    st_b[0] = 0;
    st_b[1] = 0;
    @(negedge clock);
    start_b = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start_b = 1'b0;
    repeat (4) @(negedge clock);
    chk("lat_ts:in_flight", {30'd0, busy_b, read_b}, 2'b10);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    measure(1'b1, 1'b1, 1, ca, cb);
    if (cb < 0) measure(1'b0, 1'b1, 1, n0, cb);
    @(negedge clock);
    check_result(1, EXP_ID_B, EXP_TS, 1'b0, cb, 7, "post_reset_b");
    check_result(0, EXP_ID_A, EXP_TS, 1'b0, ca, 3, "post_reset_a");

    // Randomized checks against the cycle/compare model.
    for (int i = 0; i < 10; i++) begin
      int sel;
      sel = i % 2;
      w0 = ($urandom_range(0, 1) != 0) ? ((sel != 0) ? EXP_ID_B : EXP_ID_A) : $urandom;
      w1 = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom;
      run_one(sel, w0, w1, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    chk("b_stall_hold", viol_b, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
